// File: rtl/mips_pkg.sv
// Shared definitions for the ID-stage decoder feeding the EX-stage ALU:
// ALUCode values, MIPS opcode/funct/REGIMM codes and the ID/EX bundle type.
// Optional feature macro: ILLEGAL_INSN_EN adds an "illegal" flag to the bundle.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // ALUCode values understood by the EX-stage ALU
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_AND  = 5'b00001;
    localparam logic [4:0] ALU_XOR  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_NOR  = 5'b00100;
    localparam logic [4:0] ALU_SUB  = 5'b00101;
    localparam logic [4:0] ALU_ANDI = 5'b00110;
    localparam logic [4:0] ALU_XORI = 5'b00111;
    localparam logic [4:0] ALU_ORI  = 5'b01000;
    localparam logic [4:0] ALU_JR   = 5'b01001;
    localparam logic [4:0] ALU_BEQ  = 5'b01010;
    localparam logic [4:0] ALU_BNE  = 5'b01011;
    localparam logic [4:0] ALU_BGEZ = 5'b01100;
    localparam logic [4:0] ALU_BGTZ = 5'b01101;
    localparam logic [4:0] ALU_BLEZ = 5'b01110;
    localparam logic [4:0] ALU_BLTZ = 5'b01111;
    localparam logic [4:0] ALU_SLL  = 5'b10000;
    localparam logic [4:0] ALU_SRL  = 5'b10001;
    localparam logic [4:0] ALU_SRA  = 5'b10010;
    localparam logic [4:0] ALU_SLT  = 5'b10011;
    localparam logic [4:0] ALU_SLTU = 5'b10100;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // REGIMM rt-field codes
    localparam logic [4:0] RI_BLTZ = 5'd0;
    localparam logic [4:0] RI_BGEZ = 5'd1;

    // Link register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic                  valid;
        logic [4:0]            alu_code;
        logic [DATA_W-1:0]     alu_a;
        logic [DATA_W-1:0]     alu_b;
        logic [REG_ADDR_W-1:0] wr_reg;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     store_data;
        logic                  is_branch;
        logic                  ovf_chk;
`ifdef ILLEGAL_INSN_EN
        logic                  illegal;
`endif
    } id_ex_t;

    // A bubble is all-zero: invalid, ALUCode add, zero operands, no enables
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_decode_if.sv
// ID -> EX bundle interface. The master side is the decode stage (drives
// ex_*), the slave side is the surrounding pipeline (drives id_* and hazards).
// Optional feature macro: ILLEGAL_INSN_EN adds ex_illegal.
interface id_ex_decode_if;
    import mips_pkg::*;

    logic                  id_valid;
    logic [DATA_W-1:0]     id_instr;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_pc_plus8;
    logic                  ex_hold;
    logic                  id_flush;

    logic                  ex_valid;
    logic [4:0]            ex_alu_code;
    logic [DATA_W-1:0]     ex_alu_a;
    logic [DATA_W-1:0]     ex_alu_b;
    logic [REG_ADDR_W-1:0] ex_wr_reg;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [DATA_W-1:0]     ex_store_data;
    logic                  ex_is_branch;
    logic                  ex_ovf_chk;
`ifdef ILLEGAL_INSN_EN
    logic                  ex_illegal;
`endif

    modport master (
        input  id_valid, id_instr, id_rs_data, id_rt_data, id_pc_plus8,
        input  ex_hold, id_flush,
        output ex_valid, ex_alu_code, ex_alu_a, ex_alu_b, ex_wr_reg,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
`ifdef ILLEGAL_INSN_EN
        output ex_illegal,
`endif
        output ex_is_branch, ex_ovf_chk
    );

    modport slave (
        output id_valid, id_instr, id_rs_data, id_rt_data, id_pc_plus8,
        output ex_hold, id_flush,
        input  ex_valid, ex_alu_code, ex_alu_a, ex_alu_b, ex_wr_reg,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
`ifdef ILLEGAL_INSN_EN
        input  ex_illegal,
`endif
        input  ex_is_branch, ex_ovf_chk
    );

endinterface

// File: rtl/mips_decoder.sv
// Purely combinational MIPS instruction decoder: instruction word plus
// forwarded operands -> ID/EX bundle (ALUCode, operands, control enables).
// Unrecognised encodings become a NOP; with ILLEGAL_INSN_EN they are flagged.
module mips_decoder
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] pc_plus8,
    output id_ex_t            dec
);

    logic [5:0]        op_s;
    logic [5:0]        funct_s;
    logic [4:0]        rt_s;
    logic [4:0]        rd_s;
    logic [4:0]        shamt_s;
    logic [15:0]       imm_s;
    logic [DATA_W-1:0] imm_sx_s;
    logic [4:0]        wr_s;
    logic              wen_s;
    logic              bad_s;

    assign op_s     = instr[31:26];
    assign rt_s     = instr[20:16];
    assign rd_s     = instr[15:11];
    assign shamt_s  = instr[10:6];
    assign funct_s  = instr[5:0];
    assign imm_s    = instr[15:0];
    assign imm_sx_s = {{16{imm_s[15]}}, imm_s};

    // Decode op/funct/rt into the ALU bundle; writes to $0 never enable writeback
    always_comb begin
        dec          = ID_EX_BUBBLE;
        dec.valid    = 1'b1;
        dec.alu_code = ALU_ADD;
        wr_s         = 5'd0;
        wen_s        = 1'b0;
        bad_s        = 1'b0;

        case (op_s)
            OP_RTYPE: begin
                dec.alu_a = rs_data;
                dec.alu_b = rt_data;
                wr_s      = rd_s;
                wen_s     = 1'b1;
                case (funct_s)
                    FN_ADD:  begin dec.alu_code = ALU_ADD; dec.ovf_chk = 1'b1; end
                    FN_ADDU: dec.alu_code = ALU_ADD;
                    FN_SUB:  begin dec.alu_code = ALU_SUB; dec.ovf_chk = 1'b1; end
                    FN_SUBU: dec.alu_code = ALU_SUB;
                    FN_AND:  dec.alu_code = ALU_AND;
                    FN_OR:   dec.alu_code = ALU_OR;
                    FN_XOR:  dec.alu_code = ALU_XOR;
                    FN_NOR:  dec.alu_code = ALU_NOR;
                    FN_SLT:  dec.alu_code = ALU_SLT;
                    FN_SLTU: dec.alu_code = ALU_SLTU;
                    FN_JR: begin
                        dec.alu_code = ALU_JR;
                        wr_s         = 5'd0;
                        wen_s        = 1'b0;
                    end
                    FN_SLL:  begin dec.alu_code = ALU_SLL; dec.alu_a = {27'd0, shamt_s}; end
                    FN_SRL:  begin dec.alu_code = ALU_SRL; dec.alu_a = {27'd0, shamt_s}; end
                    FN_SRA:  begin dec.alu_code = ALU_SRA; dec.alu_a = {27'd0, shamt_s}; end
                    FN_SLLV: begin dec.alu_code = ALU_SLL; dec.alu_a = {27'd0, rs_data[4:0]}; end
                    FN_SRLV: begin dec.alu_code = ALU_SRL; dec.alu_a = {27'd0, rs_data[4:0]}; end
                    FN_SRAV: begin dec.alu_code = ALU_SRA; dec.alu_a = {27'd0, rs_data[4:0]}; end
                    FN_JALR: begin
                        dec.alu_code = ALU_ADD;
                        dec.alu_a    = pc_plus8;
                        dec.alu_b    = 32'd0;
                    end
                    default: bad_s = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                dec.alu_a     = rs_data;
                dec.alu_b     = rt_data;
                dec.is_branch = 1'b1;
                case (rt_s)
                    RI_BLTZ: dec.alu_code = ALU_BLTZ;
                    RI_BGEZ: dec.alu_code = ALU_BGEZ;
                    default: bad_s = 1'b1;
                endcase
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec.alu_a     = rs_data;
                dec.alu_b     = rt_data;
                dec.is_branch = 1'b1;
                case (op_s)
                    OP_BEQ:  dec.alu_code = ALU_BEQ;
                    OP_BNE:  dec.alu_code = ALU_BNE;
                    OP_BLEZ: dec.alu_code = ALU_BLEZ;
                    default: dec.alu_code = ALU_BGTZ;
                endcase
            end
            OP_J: begin
                dec.alu_code = ALU_ADD;
            end
            OP_JAL: begin
                dec.alu_code = ALU_ADD;
                dec.alu_a    = pc_plus8;
                dec.alu_b    = 32'd0;
                wr_s         = REG_RA;
                wen_s        = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
                dec.alu_a = rs_data;
                dec.alu_b = imm_sx_s;
                wr_s      = rt_s;
                wen_s     = 1'b1;
                case (op_s)
                    OP_ADDI: begin dec.alu_code = ALU_ADD; dec.ovf_chk = 1'b1; end
                    OP_SLTI:  dec.alu_code = ALU_SLT;
                    OP_SLTIU: dec.alu_code = ALU_SLTU;
                    OP_LW:   begin dec.alu_code = ALU_ADD; dec.mem_read = 1'b1; end
                    default:  dec.alu_code = ALU_ADD;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.alu_a = rs_data;
                dec.alu_b = {16'h0000, imm_s};
                wr_s      = rt_s;
                wen_s     = 1'b1;
                case (op_s)
                    OP_ANDI: dec.alu_code = ALU_ANDI;
                    OP_ORI:  dec.alu_code = ALU_ORI;
                    default: dec.alu_code = ALU_XORI;
                endcase
            end
            OP_LUI: begin
                dec.alu_code = ALU_ADD;
                dec.alu_a    = 32'd0;
                dec.alu_b    = {imm_s, 16'h0000};
                wr_s         = rt_s;
                wen_s        = 1'b1;
            end
            OP_SW: begin
                dec.alu_code   = ALU_ADD;
                dec.alu_a      = rs_data;
                dec.alu_b      = imm_sx_s;
                dec.mem_write  = 1'b1;
                dec.store_data = rt_data;
            end
            default: bad_s = 1'b1;
        endcase

        if (bad_s) begin
            // NOP: valid, ALUCode add, zero operands, every enable off
            dec           = ID_EX_BUBBLE;
            dec.valid     = 1'b1;
            dec.wr_reg    = 5'd0;
            dec.reg_write = 1'b0;
        end else begin
            dec.wr_reg    = wr_s;
            dec.reg_write = wen_s & (wr_s != 5'd0);
        end

`ifdef ILLEGAL_INSN_EN
        dec.illegal = bad_s;
`endif
    end

endmodule

// File: rtl/id_ex_decode.sv
// ID/EX pipeline register for the ALU interface. Decoding is delegated to
// mips_decoder; this level only applies reset > hold > flush/invalid > load.
// Optional feature macro: ILLEGAL_INSN_EN drives ex_illegal.
module id_ex_decode
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    id_ex_decode_if.master bus
);

    id_ex_t dec_s;
    id_ex_t ex_d;
    id_ex_t ex_q;

    mips_decoder u_decoder (
        .instr    (bus.id_instr),
        .rs_data  (bus.id_rs_data),
        .rt_data  (bus.id_rt_data),
        .pc_plus8 (bus.id_pc_plus8),
        .dec      (dec_s)
    );

    // Next ID/EX contents: hold wins over flush, flush/invalid insert a bubble
    always_comb begin
        ex_d = ex_q;
        if (bus.ex_hold) begin
            ex_d = ex_q;
        end else if (bus.id_flush || !bus.id_valid) begin
            ex_d = ID_EX_BUBBLE;
        end else begin
            ex_d = dec_s;
        end
    end

    // ID/EX register; synchronous reset overrides hold and flush
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= ID_EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_code   = ex_q.alu_code;
    assign bus.ex_alu_a      = ex_q.alu_a;
    assign bus.ex_alu_b      = ex_q.alu_b;
    assign bus.ex_wr_reg     = ex_q.wr_reg;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_store_data = ex_q.store_data;
    assign bus.ex_is_branch  = ex_q.is_branch;
    assign bus.ex_ovf_chk    = ex_q.ovf_chk;
`ifdef ILLEGAL_INSN_EN
    assign bus.ex_illegal    = ex_q.illegal;
`endif

endmodule

// File: doc/id_ex_decode.md
Name: id_ex_decode

Overview:
- ID-stage producer of the EX-stage ALU interface.
- Decodes the fetched MIPS instruction into the 5-bit ALUCode plus the A/B operands the ALU consumes.
- Registers the decoded bundle into the ID/EX pipeline register, with hold and bubble-insert control from the hazard unit.
- The EX stage's ALU reads only these registered outputs.

Parameters:
- DATA_W, 32: operand width. Only 32 is supported.
- REG_ADDR_W, 5: register-file address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  instruction word
- id_rs_data  in  32  register rs read data, already forwarded
- id_rt_data  in  32  register rt read data, already forwarded
- id_pc_plus8  in  32  link value for jal/jalr
- ex_hold  in  1  EX stalled: hold the ID/EX contents
- id_flush  in  1  load next ID/EX contents as a bubble
- ex_valid  out  1  EX instruction is real
- ex_alu_code  out  5  ALUCode to the ALU
- ex_alu_a  out  32  ALU operand A
- ex_alu_b  out  32  ALU operand B
- ex_wr_reg  out  5  destination register
- ex_reg_write  out  1  writeback enable
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_store_data  out  32  rt data for a store
- ex_is_branch  out  1  ALU Result is a branch condition
- ex_ovf_chk  out  1  ALU overflow must trap (add/sub/addi only)

Behaviour:
- ALUCode encoding:
  - add 00000, and 00001, xor 00010, or 00011, nor 00100, sub 00101
  - andi 00110, xori 00111, ori 01000, jr 01001
  - beq 01010, bne 01011, bgez 01100, bgtz 01101, blez 01110, bltz 01111
  - sll 10000, srl 10001, sra 10010, slt 10011, sltu 10100
- R-type (op=0), by funct; A=rs, B=rt, dest=rd:
  - 20/21 add; 22/23 sub; 24 and; 25 or; 26 xor; 27 nor; 2A slt; 2B sltu; 08 jr (no write).
  - Shifts 00 sll, 02 srl, 03 sra: A={27'b0,shamt}, B=rt.
  - 04/06/07 (variable shifts): A={27'b0,rs[4:0]}, B=rt.
  - 09 jalr: add, A=pc+8, B=0, dest=rd.
- I-type, dest=rt:
  - 08/09 add with sign-extended immediate.
  - 0A slt, 0B sltu: sign-extended immediate.
  - 0C andi, 0D ori, 0E xori: raw immediate in B[15:0], zero-extended.
  - 0F lui: add, A=0, B={imm,16'b0}.
  - 23 lw: add, sign-extended immediate, mem_read=1.
  - 2B sw: add, sign-extended immediate, mem_write=1, no write.
- Branches (no write, is_branch=1, A=rs, B=rt):
  - 04 beq, 05 bne, 06 blez, 07 bgtz.
  - 01 REGIMM: rt=0 bltz, rt=1 bgez.
- Jumps:
  - 03 jal: add, A=pc+8, B=0, dest=31.
  - 02 j: valid, all enables 0.
- ovf_chk=1 only for funct 20, funct 22 and op 08.
- Writes to register 0 force reg_write=0.
- Unrecognised encodings decode as a NOP: add, all enables 0.
- Bubble contents: valid=0, alu_code=00000, operands 0, all enables 0.
- Register update, in priority order each clk:
  1. reset → bubble.
  2. ex_hold → hold all outputs (flush ignored; hazard unit must reassert it).
  3. id_flush or !id_valid → bubble.
  4. Otherwise → load the decoded bundle.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs. No combinational path from inputs to outputs.
- Reset asserted mid-stream: a bubble appears on the next edge regardless of hold or flush.

Optional Feature:
- Macro ILLEGAL_INSN_EN.
- Defined: adds output ex_illegal (1 bit), registered with the same hold/flush/reset rules. It is set for unrecognised op/funct/REGIMM-rt encodings on a valid, unflushed load; the bundle is still a NOP.
- Undefined: port absent, and unrecognised encodings are silent NOPs.

Decomposition:
- Package mips_pkg:
  - ALUCode constants (the 21 codes above)
  - opcode and funct constants
  - REGIMM rt codes
  - id_ex_t struct for the registered bundle
  - bubble constant
- One combinational sub-module, mips_decoder (instr, rs/rt data, pc+8 → id_ex_t). The top holds only the register and priority logic.

Test Plan:
- add $3,$1,$2 (0x00221820), rs=5, rt=7 → next cycle: alu_code=00000, A=5, B=7, wr_reg=3, reg_write=1, ovf_chk=1.
- sra $4,$5,3 (0x000520C3), rt=0x80000000 → alu_code=10010, A=3, B=0x80000000, wr_reg=4.
- andi $2,$1,0x8001 vs addi $2,$1,-1:
  - andi → B=0x00008001, alu_code=00110.
  - addi → B=0xFFFFFFFF, ovf_chk=1.
- bgez $1 (0x04210004) → alu_code=01100, is_branch=1, reg_write=0.
- Hold then flush:
  - Load lw; next cycle assert ex_hold and id_flush together → outputs unchanged.
  - Release hold with flush asserted → bubble (valid=0, all enables 0).
- Reset and register 0:
  - reset asserted during a valid add → bubble next edge.
  - addu $0,$1,$2 → reg_write=0.
  - Undefined op 0x3F → NOP; ex_illegal=1 when ILLEGAL_INSN_EN is defined.
